// File: rtl/encrypt_config_pkg.sv
// Shared configuration for the byte encrypter: default permutation/keys,
// config-set types and control-state encoding.
package encrypt_config;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned PERM_W   = 3;
    localparam int unsigned NUM_BITS = 8;
    localparam int unsigned ADDR_W   = 4;

    typedef logic [PERM_W-1:0]             perm_idx_t;
    typedef perm_idx_t [NUM_BITS-1:0]      perm_t;
    typedef logic [DATA_W-1:0]             key_t;

    localparam perm_idx_t PERM_0 = 3'd7;
    localparam perm_idx_t PERM_1 = 3'd6;
    localparam perm_idx_t PERM_2 = 3'd5;
    localparam perm_idx_t PERM_3 = 3'd4;
    localparam perm_idx_t PERM_4 = 3'd3;
    localparam perm_idx_t PERM_5 = 3'd2;
    localparam perm_idx_t PERM_6 = 3'd1;
    localparam perm_idx_t PERM_7 = 3'd0;

    localparam key_t XOR_KEY1 = 8'hDE;
    localparam key_t XOR_KEY2 = 8'hAD;
    localparam key_t XOR_KEY3 = 8'hBE;

    localparam logic [ADDR_W-1:0] ADDR_KEY1 = 4'd8;
    localparam logic [ADDR_W-1:0] ADDR_KEY2 = 4'd9;
    localparam logic [ADDR_W-1:0] ADDR_KEY3 = 4'd10;

    typedef struct packed {
        perm_t perm;
        key_t  key1;
        key_t  key2;
        key_t  key3;
    } cfg_set_t;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_COMMIT = 2'd2
    } ctrl_state_t;

    function automatic cfg_set_t default_cfg();
        cfg_set_t c;
        c.perm = {PERM_7, PERM_6, PERM_5, PERM_4, PERM_3, PERM_2, PERM_1, PERM_0};
        c.key1 = XOR_KEY1;
        c.key2 = XOR_KEY2;
        c.key3 = XOR_KEY3;
        return c;
    endfunction

endpackage

// File: rtl/byte_encrypter_permute.sv
// Combinational bit permutation: result bit i takes data bit perm[i].
module byte_permute
    import encrypt_config::*;
(
    input  logic [DATA_W-1:0] data,
    input  perm_t             perm,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        result = '0;
        for (int unsigned i = 0; i < NUM_BITS; i++) begin
            result[i] = data[perm[i]];
        end
    end

endmodule

// File: rtl/byte_encrypter.sv
// Three-stage XOR/permute/XOR/add byte encrypter with shadowed configuration
// that is swapped in only after the pipeline has drained.
module byte_encrypter
    import encrypt_config::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    input  logic              cfg_wr,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              cfg_commit,
    output logic              cfg_ok,
    output logic              cfg_err
);

    ctrl_state_t       state, state_next;
    cfg_set_t          active, shadow;
    logic              advance, pipe_empty, perm_bijective;
    logic              commit_ok_c, commit_err_c;
    logic [NUM_BITS-1:0] perm_seen;
    logic              s1_valid, s2_valid, s3_valid;
    logic [DATA_W-1:0] s1_data, s2_data, s3_data, permuted;

    assign advance    = out_ready || !out_valid;
    assign in_ready   = advance && (state == ST_RUN);
    assign pipe_empty = !(s1_valid || s2_valid || s3_valid);

    // Shadow permutation is valid only if every source bit is used once.
    always_comb begin
        perm_seen = '0;
        for (int unsigned i = 0; i < NUM_BITS; i++) begin
            perm_seen[shadow.perm[i]] = 1'b1;
        end
        perm_bijective = &perm_seen;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        commit_ok_c  = 1'b0;
        commit_err_c = 1'b0;
        case (state)
            ST_RUN:    if (cfg_commit) state_next = ST_DRAIN;
            ST_DRAIN:  if (pipe_empty) state_next = ST_COMMIT;
            ST_COMMIT: begin
                state_next   = ST_RUN;
                commit_ok_c  = perm_bijective;
                commit_err_c = !perm_bijective;
            end
            default:   state_next = ST_RUN;
        endcase
    end

    // Shadow writes are accepted in any state; addresses 11-15 are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= default_cfg();
        end else if (cfg_wr) begin
            if (!cfg_addr[3]) begin
                shadow.perm[cfg_addr[2:0]] <= cfg_data[PERM_W-1:0];
            end else begin
                case (cfg_addr)
                    ADDR_KEY1: shadow.key1 <= cfg_data;
                    ADDR_KEY2: shadow.key2 <= cfg_data;
                    ADDR_KEY3: shadow.key3 <= cfg_data;
                    default:   ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active  <= default_cfg();
            cfg_ok  <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cfg_ok  <= commit_ok_c;
            cfg_err <= commit_err_c;
            if (commit_ok_c) begin
                active <= shadow;
            end
        end
    end

    byte_permute u_permute (
        .data   (s1_data),
        .perm   (active.perm),
        .result (permuted)
    );

    // Whole pipeline moves in lockstep; it freezes when the output is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s3_valid  <= 1'b0;
            out_valid <= 1'b0;
            s1_data   <= '0;
            s2_data   <= '0;
            s3_data   <= '0;
            out_data  <= '0;
        end else if (advance) begin
            s1_valid  <= in_valid && in_ready;
            s2_valid  <= s1_valid;
            s3_valid  <= s2_valid;
            out_valid <= s3_valid;
            s1_data   <= in_data ^ active.key1;
            s2_data   <= permuted;
            s3_data   <= s2_data ^ active.key2;
            if (s3_valid) begin
                out_data <= DATA_W'(s3_data + active.key3);
            end
        end
    end

endmodule

// File: tb/tb_byte_encrypter.sv
// Self-checking bench for byte_encrypter using a behavioural cipher model.
module tb_byte_encrypter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready = 1'b1;
    logic       cfg_wr = 1'b0;
    logic [3:0] cfg_addr = 4'h0;
    logic [7:0] cfg_data = 8'h00;
    logic       cfg_commit = 1'b0;
    logic       cfg_ok;
    logic       cfg_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0] m_perm [8];
    logic [7:0] m_k1, m_k2, m_k3;
    logic [2:0] sh_perm [8];
    logic [7:0] sh_k1, sh_k2, sh_k3;

    always #5 clk = ~clk;

    byte_encrypter dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .cfg_wr     (cfg_wr),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_commit (cfg_commit),
        .cfg_ok     (cfg_ok),
        .cfg_err    (cfg_err)
    );

    function automatic logic [7:0] model_enc(input logic [7:0] d);
        logic [7:0] x, y;
        x = d ^ m_k1;
        for (int i = 0; i < 8; i++) y[i] = x[m_perm[i]];
        y = y ^ m_k2;
        return 8'(y + m_k3);
    endfunction

    function automatic bit model_perm_ok();
        int cnt [8];
        for (int i = 0; i < 8; i++) cnt[i] = 0;
        for (int i = 0; i < 8; i++) cnt[sh_perm[i]]++;
        for (int i = 0; i < 8; i++) if (cnt[i] != 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) begin
            m_perm[i]  = 3'(7 - i);
            sh_perm[i] = 3'(7 - i);
        end
        m_k1 = 8'hDE; m_k2 = 8'hAD; m_k3 = 8'hBE;
        sh_k1 = 8'hDE; sh_k2 = 8'hAD; sh_k3 = 8'hBE;
    endfunction

    function automatic void model_commit();
        for (int i = 0; i < 8; i++) m_perm[i] = sh_perm[i];
        m_k1 = sh_k1; m_k2 = sh_k2; m_k3 = sh_k3;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; cfg_wr = 1'b0; cfg_commit = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        cfg_wr = 1'b1; cfg_addr = a; cfg_data = d;
        @(negedge clk);
        cfg_wr = 1'b0;
        if (a < 4'd8) sh_perm[a[2:0]] = d[2:0];
        else if (a == 4'd8) sh_k1 = d;
        else if (a == 4'd9) sh_k2 = d;
        else if (a == 4'd10) sh_k3 = d;
    endtask

    task automatic do_commit(output bit ok, output bit err, output bit single);
        int n = 0;
        @(negedge clk); cfg_commit = 1'b1;
        @(negedge clk); cfg_commit = 1'b0;
        while (n < 20 && !(cfg_ok || cfg_err)) begin @(negedge clk); n++; end
        ok = cfg_ok; err = cfg_err;
        @(negedge clk);
        single = !(cfg_ok || cfg_err);
    endtask

    // Drives a byte list with optional input gaps and random backpressure, collecting outputs.
    task automatic run_stream(input logic [7:0] data[$], input int ready_pct, input bit gaps,
                              output logic [7:0] got[$], output int stall_viol, output bit timeout);
        int  idx = 0, cyc = 0;
        bit  prev_stall = 1'b0;
        logic [7:0] prev_data = 8'h00;
        got.delete(); stall_viol = 0; timeout = 1'b0;
        while (got.size() < data.size()) begin
            if (cyc >= 20000) begin timeout = 1'b1; break; end
            @(negedge clk);
            in_valid  = (idx < data.size()) && (!gaps || $urandom_range(0, 3) != 0);
            in_data   = (idx < data.size()) ? data[idx] : 8'($urandom);
            out_ready = ($urandom_range(1, 100) <= ready_pct);
            #1;
            if (prev_stall && out_data !== prev_data) stall_viol++;
            if (in_valid && in_ready) idx++;
            if (out_valid && out_ready) got.push_back(out_data);
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
        n_checks++; if (cfg_ok !== 1'b0 || cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_pulses: got ok=%b err=%b expected 0/0", cfg_ok, cfg_err); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_latency(input logic [7:0] d, input logic [7:0] exp);
        int lat = 0;
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; in_data = d;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL latency_in_ready: got %b expected 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (lat < 10 && out_valid !== 1'b1) begin @(posedge clk); #1; lat++; end
        n_checks++; if (lat != 3) begin n_fail++; $display("FAIL latency_cycles: got %0d expected 3", lat); end
        n_checks++; if (out_data !== exp) begin n_fail++; $display("FAIL latency_data in=%h: got %h expected %h", d, out_data, exp); end
        n_checks++; if (model_enc(d) !== exp) begin n_fail++; $display("FAIL model_vs_const in=%h: got %h expected %h", d, model_enc(d), exp); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vin [3];
        logic [7:0] vexp [3];
        vin[0] = 8'h00; vin[1] = 8'hFF; vin[2] = 8'h00;
        vexp[0] = 8'h94; vexp[1] = 8'hE7; vexp[2] = 8'h94;
        apply_reset();
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = vin[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== vexp[i]) begin
                n_fail++; $display("FAIL back_to_back[%0d]: got v=%b d=%h expected v=1 d=%h", i, out_valid, out_data, vexp[i]);
            end
        end
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL back_to_back_tail: got out_valid=%b expected 0", out_valid); end
    endtask

    task automatic test_random_stream(input int count, input int ready_pct, input string tag);
        logic [7:0] din[$], dexp[$], got[$];
        int viol; bit tmo; int errs = 0;
        for (int i = 0; i < count; i++) begin
            din.push_back(8'($urandom));
            dexp.push_back(model_enc(din[i]));
        end
        run_stream(din, ready_pct, 1'b1, got, viol, tmo);
        n_checks++; if (tmo || got.size() != dexp.size()) begin n_fail++; $display("FAIL %s_count: got %0d bytes expected %0d", tag, got.size(), dexp.size()); end
        for (int i = 0; i < got.size() && i < dexp.size(); i++) begin
            n_checks++;
            if (got[i] !== dexp[i]) begin
                n_fail++; errs++;
                if (errs < 8) $display("FAIL %s_data[%0d]: got %h expected %h", tag, i, got[i], dexp[i]);
            end
        end
        n_checks++; if (viol != 0) begin n_fail++; $display("FAIL %s_stall_stable: got %0d changes expected 0", tag, viol); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_duplicate: got out_valid=%b expected 0", tag, out_valid); end
        end
    endtask

    task automatic test_bad_perm();
        bit ok, err, single;
        apply_reset();
        for (int i = 0; i < 8; i++) cfg_write(4'(i), 8'h00);
        do_commit(ok, err, single);
        n_checks++; if (model_perm_ok() !== 1'b0) begin n_fail++; $display("FAIL bad_perm_model: got %b expected 0", model_perm_ok()); end
        n_checks++; if (err !== 1'b1 || ok !== 1'b0) begin n_fail++; $display("FAIL bad_perm_pulse: got ok=%b err=%b expected 0/1", ok, err); end
        n_checks++; if (single !== 1'b1) begin n_fail++; $display("FAIL bad_perm_single: got %b expected 1", single); end
        test_latency(8'h00, 8'h94);
    endtask

    task automatic test_identity();
        bit ok, err, single;
        logic [7:0] din[$], got[$];
        int viol; bit tmo;
        apply_reset();
        for (int i = 0; i < 8; i++) cfg_write(4'(i), 8'(i));
        cfg_write(4'd8, 8'h00); cfg_write(4'd9, 8'h00); cfg_write(4'd10, 8'h01);
        for (int a = 11; a < 16; a++) cfg_write(4'(a), 8'($urandom));
        do_commit(ok, err, single);
        n_checks++; if (ok !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL identity_pulse: got ok=%b err=%b expected 1/0", ok, err); end
        n_checks++; if (single !== 1'b1) begin n_fail++; $display("FAIL identity_single: got %b expected 1", single); end
        model_commit();
        din.push_back(8'hFF); din.push_back(8'h41);
        run_stream(din, 100, 1'b0, got, viol, tmo);
        n_checks++; if (tmo || got.size() != 2) begin n_fail++; $display("FAIL identity_count: got %0d expected 2", got.size()); end
        else begin
            n_checks++; if (got[0] !== 8'h00) begin n_fail++; $display("FAIL identity_wrap: got %h expected 00", got[0]); end
            n_checks++; if (got[1] !== 8'h42) begin n_fail++; $display("FAIL identity_inc: got %h expected 42", got[1]); end
        end
    endtask

    task automatic test_random_config();
        bit ok, err, single, exp_ok;
        logic [2:0] p [8];
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < 8; i++) p[i] = 3'(i);
            if (it % 2 == 0) begin
                for (int i = 7; i > 0; i--) begin
                    int j; logic [2:0] t;
                    j = $urandom_range(0, i); t = p[i]; p[i] = p[j]; p[j] = t;
                end
            end else begin
                for (int i = 0; i < 8; i++) p[i] = 3'($urandom);
            end
            for (int i = 0; i < 8; i++) cfg_write(4'(i), {5'($urandom), p[i]});
            cfg_write(4'd8, 8'($urandom)); cfg_write(4'd9, 8'($urandom)); cfg_write(4'd10, 8'($urandom));
            exp_ok = model_perm_ok();
            do_commit(ok, err, single);
            n_checks++;
            if (ok !== exp_ok || err !== !exp_ok) begin
                n_fail++; $display("FAIL rand_cfg_pulse[%0d]: got ok=%b err=%b expected ok=%b", it, ok, err, exp_ok);
            end
            if (exp_ok) model_commit();
            test_random_stream(48, 70, "rand_cfg");
        end
    endtask

    task automatic test_drain_commit();
        logic [7:0] b [3];
        logic [7:0] e [3];
        int got = 0, ok_cyc = -1, last_cyc = -1;
        apply_reset();
        for (int i = 0; i < 8; i++) cfg_write(4'(i), 8'(i));
        cfg_write(4'd8, 8'h00); cfg_write(4'd9, 8'h00); cfg_write(4'd10, 8'h01);
        for (int i = 0; i < 3; i++) begin b[i] = 8'($urandom); e[i] = model_enc(b[i]); end
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = b[i];
            #1;
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL drain_fill[%0d]: got in_ready=%b expected 1", i, in_ready); end
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        cfg_commit = 1'b1;
        @(negedge clk);
        cfg_commit = 1'b0;
        in_valid = 1'b1; in_data = 8'h55;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (in_ready !== 1'b0 || cfg_ok !== 1'b0) begin
                n_fail++; $display("FAIL drain_block[%0d]: got in_ready=%b cfg_ok=%b expected 0/0", i, in_ready, cfg_ok);
            end
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            #1;
            if (out_valid === 1'b1) begin
                n_checks++;
                if (got >= 3 || out_data !== e[got < 3 ? got : 0]) begin
                    n_fail++; $display("FAIL drain_old_keys[%0d]: got %h expected %h", got, out_data, e[got < 3 ? got : 0]);
                end
                got++; last_cyc = c;
            end
            if (cfg_ok === 1'b1 && ok_cyc < 0) ok_cyc = c;
            @(negedge clk);
        end
        n_checks++; if (got != 3) begin n_fail++; $display("FAIL drain_count: got %0d expected 3", got); end
        n_checks++; if (ok_cyc < 0 || ok_cyc <= last_cyc) begin n_fail++; $display("FAIL drain_ok_order: got ok at %0d last byte at %0d expected ok after bytes", ok_cyc, last_cyc); end
        model_commit();
        test_random_stream(1, 100, "drain_new");
        test_latency(8'h41, 8'h42);
    endtask

    task automatic test_mid_reset();
        apply_reset();
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin in_valid = 1'b1; in_data = 8'($urandom); @(negedge clk); end
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        cfg_commit = 1'b1; @(negedge clk); cfg_commit = 1'b0;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            #1;
            n_checks++;
            if (out_valid !== 1'b0 || cfg_ok !== 1'b0 || cfg_err !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++; $display("FAIL mid_reset[%0d]: got v=%b ok=%b err=%b rdy=%b expected 0/0/0/1", i, out_valid, cfg_ok, cfg_err, in_ready);
            end
            @(negedge clk);
        end
        test_latency(8'hFF, 8'hE7);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_latency(8'h00, 8'h94);
        test_latency(8'hFF, 8'hE7);
        test_back_to_back();
        apply_reset();
        test_random_stream(256, 50, "rand_stream");
        test_bad_perm();
        test_identity();
        test_drain_commit();
        apply_reset();
        test_random_config();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
